// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// requester indices and latency counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned REQ_FETCH = 0;
    localparam int unsigned REQ_DATA  = 1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins, and a tie goes to the
// requester that did not win last time.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (valid0 && valid1) begin
            if (last_grant) grant[REQ_FETCH] = 1'b1;
            else            grant[REQ_DATA]  = 1'b1;
        end else begin
            grant[REQ_FETCH] = valid0;
            grant[REQ_DATA]  = valid1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch and a data requester onto a single memory port with a
// fixed MEM_LAT-cycle access followed by a one-cycle response pulse.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDRSIZE = 64,
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req0_valid,
    input  logic                req0_we,
    input  logic [ADDRSIZE-1:0] req0_addr,
    input  logic [WORDSIZE-1:0] req0_wdata,
    output logic                req0_ready,
    output logic                rsp0_valid,
    output logic [WORDSIZE-1:0] rsp0_rdata,

    input  logic                req1_valid,
    input  logic                req1_we,
    input  logic [ADDRSIZE-1:0] req1_addr,
    input  logic [WORDSIZE-1:0] req1_wdata,
    output logic                req1_ready,
    output logic                rsp1_valid,
    output logic [WORDSIZE-1:0] rsp1_rdata,

    output logic                mem_wren,
    output logic                mem_rden,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_d,
    input  logic [WORDSIZE-1:0] mem_q
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                last_grant;
    logic                gidx_r;
    logic                we_r;
    logic [ADDRSIZE-1:0] addr_r;
    logic [WORDSIZE-1:0] wdata_r;
    logic [WORDSIZE-1:0] rdata_r;
    logic [1:0]          grant;
    logic                final_cyc;

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign final_cyc = (state == ACCESS) && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            gidx_r     <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            rdata_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        state      <= ACCESS;
                        cnt        <= '0;
                        last_grant <= grant[REQ_DATA];
                        gidx_r     <= grant[REQ_DATA];
                        if (grant[REQ_DATA]) begin
                            we_r    <= req1_we;
                            addr_r  <= req1_addr;
                            wdata_r <= req1_wdata;
                        end else begin
                            we_r    <= req0_we;
                            addr_r  <= req0_addr;
                            wdata_r <= req0_wdata;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (final_cyc) begin
                        state <= RESP;
                        if (!we_r) rdata_r <= mem_q;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are decoded from registered state but masked by rst so that a
    // reset cycle landing mid-transaction produces no write or response pulse.
    always_comb begin
        req0_ready = !rst && (state == IDLE) && grant[REQ_FETCH];
        req1_ready = !rst && (state == IDLE) && grant[REQ_DATA];
        mem_rden   = !rst && (state == ACCESS) && !we_r;
        mem_wren   = !rst && final_cyc && we_r;
        mem_addr   = rst ? '0 : addr_r;
        mem_d      = rst ? '0 : wdata_r;
        rsp0_valid = !rst && (state == RESP) && !gidx_r;
        rsp1_valid = !rst && (state == RESP) && gidx_r;
        rsp0_rdata = (rsp0_valid && !we_r) ? rdata_r : '0;
        rsp1_rdata = (rsp1_valid && !we_r) ? rdata_r : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) checked with a
// vector table, hand sequences and a transaction-level random reference model.
module tb_mem_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst  [2];
    logic          v0   [2];
    logic          v1   [2];
    logic          we0  [2];
    logic          we1  [2];
    logic [AW-1:0] a0   [2];
    logic [AW-1:0] a1   [2];
    logic [DW-1:0] d0   [2];
    logic [DW-1:0] d1   [2];
    logic          rdy0 [2];
    logic          rdy1 [2];
    logic          rv0  [2];
    logic          rv1  [2];
    logic [DW-1:0] rd0  [2];
    logic [DW-1:0] rd1  [2];
    logic          wren [2];
    logic          rden [2];
    logic [AW-1:0] maddr[2];
    logic [DW-1:0] md   [2];
    logic [DW-1:0] mq   [2];
    logic [DW-1:0] mem  [2][256];

    int n_checks = 0;
    int n_fail   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mem_arbiter #(.ADDRSIZE(AW), .WORDSIZE(DW), .MEM_LAT((gi == 0) ? 1 : 3)) dut (
                .clk(clk), .rst(rst[gi]),
                .req0_valid(v0[gi]), .req0_we(we0[gi]), .req0_addr(a0[gi]), .req0_wdata(d0[gi]),
                .req0_ready(rdy0[gi]), .rsp0_valid(rv0[gi]), .rsp0_rdata(rd0[gi]),
                .req1_valid(v1[gi]), .req1_we(we1[gi]), .req1_addr(a1[gi]), .req1_wdata(d1[gi]),
                .req1_ready(rdy1[gi]), .rsp1_valid(rv1[gi]), .rsp1_rdata(rd1[gi]),
                .mem_wren(wren[gi]), .mem_rden(rden[gi]), .mem_addr(maddr[gi]),
                .mem_d(md[gi]), .mem_q(mq[gi])
            );
            assign mq[gi] = mem[gi][maddr[gi][7:0]];
        end
    endgenerate

    function automatic logic [63:0] init_val(input logic [7:0] a);
        return 64'hA5A5_0000_0000_0000 | 64'(a);
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Environment memory: cleared to a known pattern by each instance's reset.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst[k]) begin
                for (int a = 0; a < 256; a++) mem[k][a] <= init_val(a[7:0]);
            end else if (wren[k]) begin
                mem[k][maddr[k][7:0]] <= md[k];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int k, input logic [1:0] v, input logic [1:0] we,
                         input logic [63:0] ad0, input logic [63:0] ad1,
                         input logic [63:0] wd0, input logic [63:0] wd1);
        v0[k] = v[0]; v1[k] = v[1]; we0[k] = we[0]; we1[k] = we[1];
        a0[k] = ad0;  a1[k] = ad1;  d0[k] = wd0;    d1[k] = wd1;
    endtask

    task automatic idle(input int k);
        drive(k, 2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    task automatic chk_quiet(input int k, input string tag);
        chk({tag, "_ready"}, {rdy1[k], rdy0[k]}, 2'b00);
        chk({tag, "_rsp"},   {rv1[k], rv0[k]},   2'b00);
        chk({tag, "_en"},    {wren[k], rden[k]}, 2'b00);
        chk({tag, "_addr"},  maddr[k], '0);
        chk({tag, "_d"},     md[k], '0);
    endtask

    task automatic do_reset(input int k);
        @(posedge clk); #1;
        rst[k] = 1'b1;
        drive(k, 2'b11, 2'b11, 64'h77, 64'h99, 64'h1234, 64'h5678);
        @(negedge clk);
        chk_quiet(k, "rst_during");
        @(posedge clk); #1;
        rst[k] = 1'b0;
        idle(k);
        @(negedge clk);
        chk_quiet(k, "rst_after");
    endtask

    typedef struct {
        int          dut;
        logic [1:0]  v;
        logic [1:0]  we;
        logic [63:0] ad0, ad1, wd0, wd1;
        logic [1:0]  exp_rdy;
        logic [63:0] exp_rdata;
    } vec_t;

    // One full transaction: handshake, MEM_LAT access cycles, response cycle.
    // Requesters keep valid high with scrambled fields while busy.
    task automatic run_vec(input vec_t t);
        int          k  = t.dut;
        int          l  = lat(t.dut);
        logic        g  = t.exp_rdy[1];
        logic        w  = g ? t.we[1] : t.we[0];
        logic [63:0] ea = g ? t.ad1 : t.ad0;
        logic [63:0] ed = g ? t.wd1 : t.wd0;
        @(posedge clk); #1;
        drive(k, t.v, t.we, t.ad0, t.ad1, t.wd0, t.wd1);
        @(negedge clk);
        chk("hs_ready", {rdy1[k], rdy0[k]}, t.exp_rdy);
        chk("hs_en",    {wren[k], rden[k]}, 2'b00);
        for (int j = 1; j <= l; j++) begin
            @(posedge clk); #1;
            drive(k, 2'b11, 2'b11, 64'hFFFF, 64'hEEEE, 64'hBAD0, 64'hBAD1);
            @(negedge clk);
            chk("busy_ready", {rdy1[k], rdy0[k]}, 2'b00);
            chk("acc_rden",   rden[k], !w);
            chk("acc_wren",   wren[k], w && (j == l));
            chk("acc_addr",   maddr[k], ea);
            if (w) chk("acc_d", md[k], ed);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid",  {rv1[k], rv0[k]}, t.exp_rdy);
        chk("rsp_rdata",  g ? rd1[k] : rd0[k], t.exp_rdata);
        chk("rsp_ready",  {rdy1[k], rdy0[k]}, 2'b00);
        chk("rsp_en",     {wren[k], rden[k]}, 2'b00);
        chk("addr_hold",  maddr[k], ea);
        idle(k);
    endtask

    task automatic random_run(input int k, input int ncyc);
        logic [63:0] mm [256];
        int          l = lat(k);
        int          free_at = 0;
        int          acc_start = 0;
        logic        have_acc = 1'b0;
        logic        last = 1'b1;
        logic        acc_g = 1'b0, acc_we = 1'b0;
        logic [63:0] acc_addr = '0, acc_rdata = '0;
        for (int a = 0; a < 256; a++) mm[a] = init_val(a[7:0]);
        for (int t = 0; t < ncyc; t++) begin
            logic [1:0]  rv, rwe, exp_rdy, exp_rsp;
            logic [63:0] ra0, ra1, rw0, rw1;
            logic        g, in_acc, rsp_t;
            @(posedge clk); #1;
            rv  = 2'($urandom_range(0, 3));
            rwe = 2'($urandom_range(0, 3));
            ra0 = 64'($urandom_range(0, 7));
            ra1 = 64'($urandom_range(0, 7));
            rw0 = {$urandom, $urandom};
            rw1 = {$urandom, $urandom};
            drive(k, rv, rwe, ra0, ra1, rw0, rw1);
            exp_rdy = 2'b00;
            if (t >= free_at && rv != 2'b00) begin
                g         = (rv == 2'b11) ? !last : rv[1];
                exp_rdy   = g ? 2'b10 : 2'b01;
                acc_g     = g;
                acc_we    = g ? rwe[1] : rwe[0];
                acc_addr  = g ? ra1 : ra0;
                acc_rdata = acc_we ? '0 : mm[acc_addr[7:0]];
                if (acc_we) mm[acc_addr[7:0]] = g ? rw1 : rw0;
                acc_start = t;
                free_at   = t + l + 2;
                last      = g;
                have_acc  = 1'b1;
            end
            in_acc  = have_acc && (t >= acc_start + 1) && (t <= acc_start + l);
            rsp_t   = have_acc && (t == acc_start + l + 1);
            exp_rsp = rsp_t ? (acc_g ? 2'b10 : 2'b01) : 2'b00;
            @(negedge clk);
            chk("rnd_ready", {rdy1[k], rdy0[k]}, exp_rdy);
            chk("rnd_rden",  rden[k], in_acc && !acc_we);
            chk("rnd_wren",  wren[k], in_acc && acc_we && (t == acc_start + l));
            chk("rnd_rsp",   {rv1[k], rv0[k]}, exp_rsp);
            if (in_acc) chk("rnd_addr", maddr[k], acc_addr);
            if (rsp_t)  chk("rnd_rdata", acc_g ? rd1[k] : rd0[k], acc_rdata);
        end
        @(posedge clk); #1;
        idle(k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        vecs[0] = '{dut:0, v:2'b10, we:2'b10, ad0:64'h0,  ad1:64'h10, wd0:64'h0,    wd1:64'hDEAD, exp_rdy:2'b10, exp_rdata:64'h0};
        vecs[1] = '{dut:0, v:2'b01, we:2'b00, ad0:64'h10, ad1:64'h0,  wd0:64'h0,    wd1:64'h0,    exp_rdy:2'b01, exp_rdata:64'hDEAD};
        vecs[2] = '{dut:0, v:2'b11, we:2'b00, ad0:64'h20, ad1:64'h10, wd0:64'h0,    wd1:64'h0,    exp_rdy:2'b10, exp_rdata:64'hDEAD};
        vecs[3] = '{dut:0, v:2'b11, we:2'b01, ad0:64'h20, ad1:64'h30, wd0:64'hBEEF, wd1:64'h0,    exp_rdy:2'b01, exp_rdata:64'h0};
        vecs[4] = '{dut:0, v:2'b10, we:2'b00, ad0:64'h0,  ad1:64'h20, wd0:64'h0,    wd1:64'h0,    exp_rdy:2'b10, exp_rdata:64'hBEEF};
        vecs[5] = '{dut:0, v:2'b11, we:2'b10, ad0:64'h30, ad1:64'h31, wd0:64'h0,    wd1:64'h77,   exp_rdy:2'b01, exp_rdata:init_val(8'h30)};
        vecs[6] = '{dut:0, v:2'b01, we:2'b00, ad0:64'h21, ad1:64'h0,  wd0:64'h0,    wd1:64'h0,    exp_rdy:2'b01, exp_rdata:init_val(8'h21)};
        vecs[7] = '{dut:1, v:2'b01, we:2'b00, ad0:64'h05, ad1:64'h0,  wd0:64'h0,    wd1:64'h0,    exp_rdy:2'b01, exp_rdata:init_val(8'h05)};
        vecs[8] = '{dut:1, v:2'b10, we:2'b10, ad0:64'h0,  ad1:64'h05, wd0:64'h0,    wd1:64'h55,   exp_rdy:2'b10, exp_rdata:64'h0};
        vecs[9] = '{dut:1, v:2'b11, we:2'b00, ad0:64'h05, ad1:64'h06, wd0:64'h0,    wd1:64'h0,    exp_rdy:2'b01, exp_rdata:64'h55};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            idle(k);
        end
        repeat (2) @(posedge clk);
        do_reset(0);
        do_reset(1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Both requesters valid continuously: grants must alternate from 0.
        do_reset(0);
        for (int n = 0; n < 6; n++) begin
            vec_t t;
            t = '{dut:0, v:2'b11, we:2'b00, ad0:64'(8'h40 + n), ad1:64'(8'h80 + n),
                  wd0:64'h0, wd1:64'h0,
                  exp_rdy:((n % 2) == 0) ? 2'b01 : 2'b10,
                  exp_rdata:((n % 2) == 0) ? init_val(8'(8'h40 + n)) : init_val(8'(8'h80 + n))};
            run_vec(t);
        end

        // Reset landing on the final access cycle of a write.
        @(posedge clk); #1;
        drive(0, 2'b10, 2'b10, 64'h0, 64'h10, 64'h0, 64'h1234);
        @(negedge clk);
        chk("abort_hs_ready", {rdy1[0], rdy0[0]}, 2'b10);
        @(posedge clk); #1;
        rst[0] = 1'b1;
        idle(0);
        @(negedge clk);
        chk("abort_wren", wren[0], 1'b0);
        chk("abort_rsp_during", {rv1[0], rv0[0]}, 2'b00);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_rsp_after", {rv1[0], rv0[0]}, 2'b00);
        chk("abort_wren_after", wren[0], 1'b0);
        run_vec('{dut:0, v:2'b11, we:2'b00, ad0:64'h10, ad1:64'h11, wd0:64'h0, wd1:64'h0,
                  exp_rdy:2'b01, exp_rdata:init_val(8'h10)});

        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            random_run(k, 400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
